// File: rtl/onchip_arb_pkg.sv
// Shared types and sizing helpers for the on-chip RAM arbiter.
// Optional grant locking is compiled in with the ONCHIP_ARB_LOCK_EN macro.
package onchip_arb_pkg;

    localparam int NUM_MASTERS_DEF = 4;
    localparam int IDX_W           = $clog2(NUM_MASTERS_DEF);

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit wide for tiny configurations.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onchip_rr_picker.sv
// Combinational rotate-priority picker: the requester just after `last`
// has the highest priority, wrapping around modulo N.
module onchip_rr_picker
    import onchip_arb_pkg::*;
#(
    parameter int N  = NUM_MASTERS_DEF,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    // Scan from last+1 around the ring and take the first requester.
    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_i) + k) % N;
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o      = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between several
// Avalon-MM masters. One access per cycle; reads return one cycle after
// acceptance. Define ONCHIP_ARB_LOCK_EN to let a master hold the grant via m_lock.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int BE_W        = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [BE_W-1:0]               mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);

    localparam int IW = idx_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req, elig, gnt;
    logic [IW-1:0]          gidx;
    logic                   gvld;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_wr, sel_rd;

    logic [IW-1:0]          last_q, last_d;
    logic [ADDR_W-1:0]      addr_q;
    logic                   rd_pend_q;
    logic [IW-1:0]          rd_id_q;
    logic                   clken_q;

    assign req = m_read | m_write;

`ifdef ONCHIP_ARB_LOCK_EN
    arb_state_t    state_q;
    logic [IW-1:0] owner_q;

    // While locked, only the owner may compete for the RAM.
    always_comb begin
        elig = req;
        if (state_q == ARB_LOCKED)
            elig = req & (NUM_MASTERS'(1) << owner_q);
    end
`else
    logic unused_lock;
    assign unused_lock = ^m_lock;
    assign elig        = req;
`endif

    onchip_rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req_i     (elig),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gidx),
        .gnt_vld_o (gvld)
    );

    // Command mux: write beats read when a master asserts both.
    assign sel_addr       = m_address[gidx*ADDR_W +: ADDR_W];
    assign sel_wr         = m_write[gidx];
    assign sel_rd         = m_read[gidx] & ~m_write[gidx];

    assign mem_chipselect = gvld;
    assign mem_write      = gvld & sel_wr;
    assign mem_address    = gvld ? sel_addr : addr_q;
    assign mem_byteenable = m_byteenable[gidx*BE_W +: BE_W];
    assign mem_writedata  = m_writedata[gidx*DATA_W +: DATA_W];
    assign mem_clken      = clken_q;

    assign m_waitrequest  = ~gnt;
    assign m_readdata     = mem_readdata;

    // Decode the registered read tag into the one-hot return strobe.
    always_comb begin
        m_readdatavalid = '0;
        if (rd_pend_q)
            m_readdatavalid[rd_id_q] = 1'b1;
    end

    // Next priority pointer: granted index, or the owner on an idle lock release.
    always_comb begin
        last_d = last_q;
        if (gvld)
            last_d = gidx;
`ifdef ONCHIP_ARB_LOCK_EN
        else if (state_q == ARB_LOCKED && !m_lock[owner_q])
            last_d = owner_q;
`endif
    end

    // Pointer, held address, read-return pipeline and RAM clock enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= IW'(NUM_MASTERS - 1);
            addr_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
            clken_q   <= 1'b0;
        end else begin
            clken_q   <= 1'b1;
            last_q    <= last_d;
            rd_pend_q <= gvld & sel_rd;
            if (gvld) begin
                addr_q  <= sel_addr;
                rd_id_q <= gidx;
            end
        end
    end

`ifdef ONCHIP_ARB_LOCK_EN
    // Lock FSM. In ARB_LOCKED a grant can only go to the owner, so both the
    // release-on-transfer and release-on-idle cases reduce to m_lock[owner]=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_FREE;
            owner_q <= '0;
        end else begin
            case (state_q)
                ARB_FREE: begin
                    if (gvld && m_lock[gidx]) begin
                        state_q <= ARB_LOCKED;
                        owner_q <= gidx;
                    end
                end
                ARB_LOCKED: begin
                    if (!m_lock[owner_q])
                        state_q <= ARB_FREE;
                end
                default: state_q <= ARB_FREE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomised + directed bench for onchip_mem_arbiter with a reference model
// (ideal RAM contents, round-robin rule) and a read-return scoreboard.
module tb_onchip_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*AW-1:0] m_address;
    logic [N*BW-1:0] m_byteenable;
    logic [N-1:0]    m_read, m_write, m_lock;
    logic [N*DW-1:0] m_writedata;
    logic [N-1:0]    m_waitrequest, m_readdatavalid;
    logic [DW-1:0]   m_readdata;
    logic [AW-1:0]   mem_address;
    logic [BW-1:0]   mem_byteenable;
    logic            mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0]   mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata), .m_lock(m_lock),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Single-port RAM with registered address (1-cycle read)
    bit [DW-1:0] ram [0:(1<<AW)-1];
    bit [DW-1:0] ram_q;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int id; logic [DW-1:0] data; } exp_t;
    exp_t           exp_q[$];
    logic [DW-1:0]  ref_mem [int];
    int             last, owner;
    logic [AW-1:0]  hold;
    logic [N-1:0]   dut_gnt;

    logic [N-1:0]   p_rd, p_wr, p_lk;
    logic [AW-1:0]  p_addr [N];
    logic [BW-1:0]  p_be   [N];
    logic [DW-1:0]  p_data [N];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic mdl_reset();
        last = N - 1; owner = -1; hold = '0;
        exp_q.delete();
        p_rd = '0; p_wr = '0; p_lk = '0;
        for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_be[i] = '0; p_data[i] = '0; end
    endtask

    task automatic req(input int i, input bit rd, input bit wr, input int a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d, input bit lk);
        p_rd[i] = rd; p_wr[i] = wr; p_addr[i] = AW'(a); p_be[i] = be; p_data[i] = d; p_lk[i] = lk;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            m_read[i] = p_rd[i]; m_write[i] = p_wr[i]; m_lock[i] = p_lk[i];
            m_address[i*AW +: AW]    = p_addr[i];
            m_byteenable[i*BW +: BW] = p_be[i];
            m_writedata[i*DW +: DW]  = p_data[i];
        end
    endtask

    // One bus cycle: drive pending requests, predict and check the grant,
    // update the model, advance to the next negedge.
    task automatic step();
        logic [N-1:0]  el, eg;
        logic [DW-1:0] w;
        int            g;
        drive();
        #1;
        el = p_rd | p_wr;
        if (owner >= 0) el = el & (N'(1) << owner);
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (g < 0 && el[i]) g = i;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        dut_gnt = ~m_waitrequest;
        chk("grant", dut_gnt, eg);
        chk("chipselect", mem_chipselect, g >= 0);
        if (g >= 0) begin
            chk("mem_addr", mem_address, p_addr[g]);
            chk("mem_write", mem_write, p_wr[g]);
            if (p_wr[g]) begin
                chk("mem_wdata", mem_writedata, p_data[g]);
                chk("mem_be", mem_byteenable, p_be[g]);
                w = ref_rd(p_addr[g]);
                for (int b = 0; b < BW; b++)
                    if (p_be[g][b]) w[8*b +: 8] = p_data[g][8*b +: 8];
                ref_mem[int'(p_addr[g])] = w;
            end else begin
                exp_q.push_back('{id: g, data: ref_rd(p_addr[g])});
            end
            hold = p_addr[g];
            last = g;
        end else begin
            chk("idle_addr_hold", mem_address, hold);
            chk("idle_write", mem_write, 1'b0);
        end
`ifdef ONCHIP_ARB_LOCK_EN
        if (owner < 0) begin
            if (g >= 0 && p_lk[g]) owner = g;
        end else if (g >= 0 ? !p_lk[g] : !p_lk[owner]) begin
            if (g < 0) last = owner;
            owner = -1;
        end
`endif
        if (g >= 0) begin p_rd[g] = 1'b0; p_wr[g] = 1'b0; end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    bit   mon_off = 1'b1;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!mon_off && reset_n && m_readdatavalid != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rdvalid", m_readdatavalid, '0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdvalid_id", m_readdatavalid, N'(1) << mon_e.id);
                chk("rdata", m_readdata, mon_e.data);
            end
        end
    end

    task automatic apply_reset_checks(input string tag);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_rdvalid"}, m_readdatavalid, '0);
            chk({tag, "_clken"}, mem_clken, 1'b0);
        end
        reset_n = 1'b1;
        mdl_reset();
        @(posedge clk); #1;
        chk({tag, "_clken_after"}, mem_clken, 1'b1);
        @(negedge clk);
        mon_off = 1'b0;
    endtask

    initial begin
        mdl_reset();
        drive();
        reset_n = 1'b0;
        apply_reset_checks("reset");

        // Master 2 write then read back
        req(2, 0, 1, 'h10, 4'hF, 32'hDEADBEEF, 0); step();
        req(2, 1, 0, 'h10, 4'hF, '0, 0);           step();
        chk("t2_rdvalid", m_readdatavalid, 4'b0100);
        chk("t2_rdata", m_readdata, 32'hDEADBEEF);

        // Seed 0x100+i; master 3 writes last so master 0 leads next
        for (int i = 0; i < N; i++) begin
            req(i, 0, 1, 'h100 + i, 4'hF, 32'hA0 + i, 0); step();
        end
        // Continuous reads from all masters
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                if (!p_rd[i]) req(i, 1, 0, 'h100 + i, 4'hF, '0, 0);
            step();
            chk("rr_order", dut_gnt, N'(1) << (k % N));
        end
        p_rd = '0;
        step(); step();

        // Byte-enable merge
        req(0, 0, 1, 'h20, 4'hF, 32'hFFFFFFFF, 0); step();
        req(0, 0, 1, 'h20, 4'b0010, 32'h0000AB00, 0); step();
        req(0, 1, 0, 'h20, 4'hF, '0, 0); step();
        chk("t4_rdvalid", m_readdatavalid, 4'b0001);
        chk("t4_rdata", m_readdata, 32'hFFFFABFF);

        // Read and write together: write wins, no return
        req(1, 1, 1, 5, 4'hF, 32'h13572468, 0); step();
        chk("t5_no_rdvalid", m_readdatavalid, '0);
        req(1, 1, 0, 5, 4'hF, '0, 0); step();
        chk("t5_rdata", m_readdata, 32'h13572468);

`ifdef ONCHIP_ARB_LOCK_EN
        // Master 3 holds the grant for 4 transfers
        req(3, 1, 0, 'h103, 4'hF, '0, 1); step();
        chk("lock_first", dut_gnt, 4'b1000);
        for (int t = 1; t < 4; t++) begin
            for (int i = 0; i < 3; i++) if (!p_rd[i]) req(i, 1, 0, 'h100 + i, 4'hF, '0, 0);
            req(3, 1, 0, 'h103, 4'hF, '0, t < 3);
            step();
            chk("lock_hold", dut_gnt, 4'b1000);
        end
        step();
        chk("lock_release_next", dut_gnt, 4'b0001);
        for (int d = 0; d < 4; d++) step();
`endif

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_rd[i] && !p_wr[i]) begin
                    p_lk[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        bit wr;
                        wr = ($urandom_range(0, 2) == 0);
                        req(i, !wr, wr, 'h300 + $urandom_range(0, 15), BW'($urandom_range(1, 15)),
                            $urandom, ($urandom_range(0, 3) == 0));
                    end
                end
            end
            step();
        end
        for (int d = 0; d < 40 && (p_rd | p_wr) != '0; d++) begin
            p_lk = '0;
            step();
        end
        p_lk = '0;
        step(); step();
        chk("drain_empty", exp_q.size(), 0);

        // Asynchronous reset with a read in flight
        req(0, 1, 0, 'h100, 4'hF, '0, 0);
        drive();
        @(posedge clk); #1;
        mon_off = 1'b1;
        reset_n = 1'b0;
        mdl_reset();
        drive();
        #1;
        chk("midreset_rdvalid_async", m_readdatavalid, '0);
        apply_reset_checks("midreset");

        // Master 0 is first after reset
        req(1, 1, 0, 'h101, 4'hF, '0, 0);
        req(0, 1, 0, 'h100, 4'hF, '0, 0);
        step();
        chk("post_reset_first", dut_gnt, 4'b0001);
        step(); step(); step();
        chk("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
